pmos_power_gate_sequencer: RTL and testbench



---
 rtl/pmos_power_gate_sequencer.sv | 139 +++++++++++++
 tb/tb_pmos_power_gate_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pmos_power_gate_sequencer.sv
// Staged PMOS header-switch sequencer with isolation and request/ack handshake.
// Optional PWR_GOOD_CHECK_EN adds a pwr_good input that gates entry into ON.
`timescale 1ns/1ps
module pmos_power_gate_sequencer #(
  parameter int N_STAGES    = 4,
  parameter int STAGE_DELAY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwr_req,
`ifdef PWR_GOOD_CHECK_EN
  input  logic                pwr_good,
`endif
  output logic                pwr_ack,
  output logic [N_STAGES-1:0] gate_n,
  output logic                iso_en,
  output logic                busy
);

  localparam int CW = $clog2(N_STAGES + 1);
  localparam int TW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(N_STAGES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] T_LAST   = TW'(STAGE_DELAY - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    RAMP_UP   = 3'd1,
    ON        = 3'd2,
    ISO       = 3'd3,
    RAMP_DOWN = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       on_cnt, on_cnt_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic [N_STAGES-1:0] gate_n_nxt;
  logic                iso_nxt, ack_nxt, busy_nxt;
  logic                settle_ok;

`ifdef PWR_GOOD_CHECK_EN
  assign settle_ok = pwr_good;
`else
  assign settle_ok = 1'b1;
`endif

  // Outputs are registered from the next-state values so they change on the
  // same edge as state/on_cnt and never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OFF;
      on_cnt  <= '0;
      timer   <= '0;
      gate_n  <= '1;
      iso_en  <= 1'b1;
      pwr_ack <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      on_cnt  <= on_cnt_nxt;
      timer   <= timer_nxt;
      gate_n  <= gate_n_nxt;
      iso_en  <= iso_nxt;
      pwr_ack <= ack_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    on_cnt_nxt = on_cnt;
    timer_nxt  = timer;
    case (state)
      OFF: begin
        if (pwr_req) begin
          state_nxt  = RAMP_UP;
          on_cnt_nxt = CNT_ONE;
          timer_nxt  = '0;
        end
      end
      RAMP_UP: begin
        // A dropped request reverses immediately, even while waiting to settle.
        if (!pwr_req) begin
          on_cnt_nxt = on_cnt - CNT_ONE;
          timer_nxt  = '0;
          state_nxt  = (on_cnt == CNT_ONE) ? OFF : RAMP_DOWN;
        end else if (timer != T_LAST) begin
          timer_nxt = timer + T_ONE;
        end else if (on_cnt != CNT_FULL) begin
          on_cnt_nxt = on_cnt + CNT_ONE;
          timer_nxt  = '0;
        end else if (settle_ok) begin
          state_nxt = ON;
          timer_nxt = '0;
        end
      end
      ON: begin
        if (!pwr_req) begin
          state_nxt = ISO;
        end
      end
      ISO: begin
        on_cnt_nxt = CNT_FULL - CNT_ONE;
        timer_nxt  = '0;
        state_nxt  = (CNT_FULL == CNT_ONE) ? OFF : RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (pwr_req) begin
          on_cnt_nxt = on_cnt + CNT_ONE;
          timer_nxt  = '0;
          state_nxt  = RAMP_UP;
        end else if (timer != T_LAST) begin
          timer_nxt = timer + T_ONE;
        end else begin
          on_cnt_nxt = on_cnt - CNT_ONE;
          timer_nxt  = '0;
          state_nxt  = (on_cnt == CNT_ONE) ? OFF : RAMP_DOWN;
        end
      end
      default: begin
        state_nxt  = OFF;
        on_cnt_nxt = '0;
        timer_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    gate_n_nxt = '1;
    for (int i = 0; i < N_STAGES; i++) begin
      gate_n_nxt[i] = (CW'(i) >= on_cnt_nxt);
    end
    iso_nxt  = (state_nxt != ON);
    ack_nxt  = (state_nxt == ON);
    busy_nxt = (state_nxt == RAMP_UP) || (state_nxt == ISO) || (state_nxt == RAMP_DOWN);
  end

endmodule

// File: tb/tb_pmos_power_gate_sequencer.sv
// Directed bench for pmos_power_gate_sequencer (N_STAGES=4, STAGE_DELAY=3).
`timescale 1ns/1ps
module tb_pmos_power_gate_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwr_req = 1'b0;
  logic       pwr_ack;
  logic [3:0] gate_n;
  logic       iso_en;
  logic       busy;
`ifdef PWR_GOOD_CHECK_EN
  logic       pwr_good = 1'b1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pmos_power_gate_sequencer #(.N_STAGES(4), .STAGE_DELAY(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .pwr_req (pwr_req),
`ifdef PWR_GOOD_CHECK_EN
    .pwr_good(pwr_good),
`endif
    .pwr_ack (pwr_ack),
    .gate_n  (gate_n),
    .iso_en  (iso_en),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [3:0] gate;
    logic       iso;
    logic       ack;
    logic       bsy;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic r, input logic [3:0] g, input logic i,
                              input logic a, input logic b);
    vec_t v;
    v.req = r; v.gate = g; v.iso = i; v.ack = a; v.bsy = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic i,
                         input logic a, input logic b);
    chk({tag, " gate_n"}, 32'(gate_n), 32'(g));
    chk({tag, " iso_en"}, 32'(iso_en), 32'(i));
    chk({tag, " pwr_ack"}, 32'(pwr_ack), 32'(a));
    chk({tag, " busy"}, 32'(busy), 32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    // Power-up then power-down from OFF, one record per clock edge.
    vecs[0]  = mk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 4'b1110, 1'b1, 1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 4'b1110, 1'b1, 1'b0, 1'b1);
    vecs[3]  = mk(1'b1, 4'b1110, 1'b1, 1'b0, 1'b1);
    vecs[4]  = mk(1'b1, 4'b1100, 1'b1, 1'b0, 1'b1);
    vecs[5]  = mk(1'b1, 4'b1100, 1'b1, 1'b0, 1'b1);
    vecs[6]  = mk(1'b1, 4'b1100, 1'b1, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 4'b1000, 1'b1, 1'b0, 1'b1);
    vecs[8]  = mk(1'b1, 4'b1000, 1'b1, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 4'b1000, 1'b1, 1'b0, 1'b1);
    vecs[10] = mk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    vecs[11] = mk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    vecs[12] = mk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    vecs[13] = mk(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
    vecs[14] = mk(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    vecs[16] = mk(1'b1, 4'b1000, 1'b1, 1'b0, 1'b1);
    vecs[17] = mk(1'b0, 4'b1000, 1'b1, 1'b0, 1'b1);
    vecs[18] = mk(1'b0, 4'b1000, 1'b1, 1'b0, 1'b1);
    vecs[19] = mk(1'b0, 4'b1100, 1'b1, 1'b0, 1'b1);
    vecs[20] = mk(1'b0, 4'b1100, 1'b1, 1'b0, 1'b1);
    vecs[21] = mk(1'b0, 4'b1100, 1'b1, 1'b0, 1'b1);
    vecs[22] = mk(1'b0, 4'b1110, 1'b1, 1'b0, 1'b1);
    vecs[23] = mk(1'b0, 4'b1110, 1'b1, 1'b0, 1'b1);
    vecs[24] = mk(1'b0, 4'b1110, 1'b1, 1'b0, 1'b1);
    vecs[25] = mk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    vecs[26] = mk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);

    step_n(2);
    chk_all("reset", 4'b1111, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      pwr_req = vecs[i].req;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].gate, vecs[i].iso, vecs[i].ack, vecs[i].bsy);
    end

    // Abort during ramp-up at gate_n=1100.
    pwr_req = 1'b1;
    step();
    chk_all("abort k", 4'b1110, 1'b1, 1'b0, 1'b1);
    step_n(3);
    chk_all("abort k+3", 4'b1100, 1'b1, 1'b0, 1'b1);
    pwr_req = 1'b0;
    step();
    chk_all("abort drop", 4'b1110, 1'b1, 1'b0, 1'b1);
    step_n(2);
    chk_all("abort hold", 4'b1110, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("abort off", 4'b1111, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("abort idle", 4'b1111, 1'b1, 1'b0, 1'b0);

    // Reverse during ramp-down at gate_n=1100.
    pwr_req = 1'b1;
    step_n(13);
    chk_all("rev on", 4'b0000, 1'b0, 1'b1, 1'b0);
    pwr_req = 1'b0;
    step();
    chk_all("rev iso", 4'b0000, 1'b1, 1'b0, 1'b1);
    step_n(4);
    chk_all("rev m+4", 4'b1100, 1'b1, 1'b0, 1'b1);
    pwr_req = 1'b1;
    step();
    chk_all("rev up", 4'b1000, 1'b1, 1'b0, 1'b1);
    step_n(3);
    chk_all("rev full", 4'b0000, 1'b1, 1'b0, 1'b1);
    step_n(2);
    chk_all("rev settle", 4'b0000, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("rev on2", 4'b0000, 1'b0, 1'b1, 1'b0);
    pwr_req = 1'b0;
    step_n(11);
    chk_all("rev off", 4'b1111, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-ramp, checked before the next clock edge.
    pwr_req = 1'b1;
    step_n(4);
    chk_all("midrst pre", 4'b1100, 1'b1, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk_all("midrst async", 4'b1111, 1'b1, 1'b0, 1'b0);
    pwr_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk_all("midrst after", 4'b1111, 1'b1, 1'b0, 1'b0);

`ifdef PWR_GOOD_CHECK_EN
    pwr_good = 1'b0;
    pwr_req  = 1'b1;
    step_n(10);
    chk_all("pg full", 4'b0000, 1'b1, 1'b0, 1'b1);
    step_n(2);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_all($sformatf("pg wait%0d", i), 4'b0000, 1'b1, 1'b0, 1'b1);
    end
    pwr_good = 1'b1;
    step();
    chk_all("pg on", 4'b0000, 1'b0, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
